// File: rtl/muldiv_sequencer_if.sv
// Bundle of the decode-side signals of the MULTU/DIVU sequencer.
// master = decode/pipeline side, slave = the sequencer itself.
//
// Handshake: Start is a request sampled on the rising clock edge. It is
// accepted whenever Busy is low (state IDLE or DONE). While Busy is high,
// Stall is the not-ready indication: a Start (or a HI/LO read request) seen
// during Busy is not consumed, and the pipeline must keep presenting it until
// Stall drops. Done is a one-cycle completion pulse with HI/LO valid.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Read_Req;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;
  logic             Div_Zero;
  logic             Stall;
  logic [1:0]       dbg_state;

  modport master (
    output Start, Op, SrcA, SrcB, Read_Req,
    input  HI, LO, Busy, Done, Div_Zero, Stall, dbg_state
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, Read_Req,
    output HI, LO, Busy, Done, Div_Zero, Stall, dbg_state
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer: one bit per cycle shift-add multiply or
// restoring divide, owning the HI/LO result register and the pipeline stall.
// Start sampled at edge 0 -> Busy cycles 1..WIDTH -> Done in cycle WIDTH+1.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  // Latched operation and iteration state.
  // r_acc_hi: product upper half (MUL) / partial remainder (DIV)
  // r_acc_lo: multiplier shifting out, product lower half (MUL) / quotient (DIV)
  // r_opnd  : multiplicand (MUL) / divisor (DIV)
  logic             r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opnd;

  // Architectural result registers.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div_zero;

  logic             w_busy;
  logic             w_accept;
  logic             w_last;

  // Multiply step signals.
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  // Divide step signals.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  // Selected per-iteration update.
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;

  assign w_busy   = (r_state == S_RUN);
  assign w_accept = bus.Start & ~w_busy;
  assign w_last   = w_busy & (r_cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; IDLE and DONE accept Start the same way.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = bus.Start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
  // then shift {carry, acc_hi, acc_lo} right by one.
  always_comb begin
    w_addend = r_acc_lo[0] ? {1'b0, r_opnd} : '0;
    w_sum    = {1'b0, r_acc_hi} + w_addend;
    w_mul_hi = w_sum[WIDTH:1];
    w_mul_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
  end

  // Restoring divide step. The partial remainder is always below the divisor,
  // so the shifted remainder needs WIDTH+1 bits while the result of a
  // successful subtraction fits back in WIDTH bits; the low WIDTH bits of the
  // modular difference are then exact.
  always_comb begin
    w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_div_ok  = (w_rem_sh >= {1'b0, r_opnd});
    w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
    w_div_rem = w_div_ok ? w_diff : w_rem_sh[WIDTH-1:0];
    w_div_quo = {r_acc_lo[WIDTH-2:0], w_div_ok};
  end

  // Pick the iteration result for the latched operation.
  always_comb begin
    w_it_hi = r_op ? w_div_rem : w_mul_hi;
    w_it_lo = r_op ? w_div_quo : w_mul_lo;
  end

  // Operand latch on accept, one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
    end else if (w_accept) begin
      r_op     <= bus.Op;
      r_cnt    <= CW'(WIDTH);
      r_acc_hi <= '0;
      r_acc_lo <= bus.Op ? bus.SrcA : bus.SrcB;
      r_opnd   <= bus.Op ? bus.SrcB : bus.SrcA;
    end else if (w_busy) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc_hi <= w_it_hi;
      r_acc_lo <= w_it_lo;
    end
  end

  // HI/LO load only on the final iteration edge; Div_Zero is valid for the
  // following DONE cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (w_last) begin
      r_hi       <= w_it_hi;
      r_lo       <= w_it_lo;
      r_div_zero <= r_op & (r_opnd == '0);
    end else begin
      r_div_zero <= 1'b0;
    end
  end

  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
  assign bus.Busy      = w_busy;
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Div_Zero  = r_div_zero;
  assign bus.Stall     = w_busy & (bus.Read_Req | bus.Start);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: reset, multiply, divide, hazards,
// back-to-back issue and mid-operation reset.
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present an operation for the current cycle (called at negedge).
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
  endtask

  // Driver: step cycles until Done, bounded; n returns the cycle number of
  // Done counted from the issue cycle (cycle 0), or the bound if none.
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      #1;
      n++;
      if (bus.Done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.Read_Req = 1'b1;
    #1;
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: HI=%h LO=%h expected 0/0", bus.HI, bus.LO);
    end
    checks++;
    if ({bus.Busy, bus.Done, bus.Stall, bus.Div_Zero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: Busy/Done/Stall/DivZero=%b expected 0000",
               {bus.Busy, bus.Done, bus.Stall, bus.Div_Zero});
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d expected 0", bus.dbg_state);
    end
    bus.Read_Req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_max();
    int busy_bad;
    int hold_bad;
    @(negedge clk);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.Read_Req = 1'b1;
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_read_stall: Stall=%b expected 0", bus.Stall);
    end
    busy_bad = 0;
    hold_bad = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus.Start    = 1'b0;
      bus.Read_Req = 1'b0;
      #1;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) busy_bad++;
      if (bus.HI !== 32'h0 || bus.LO !== 32'h0) hold_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL mul_busy_window: %0d bad cycles expected 0", busy_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL mul_hilo_hold: %0d cycles with changed HI/LO expected 0", hold_bad);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_max_done: Done=%b Busy=%b expected 1/0", bus.Done, bus.Busy);
    end
    checks++;
    if (bus.HI !== 32'hFFFF_FFFE || bus.LO !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mul_max_result: HI=%h LO=%h expected fffffffe/00000001", bus.HI, bus.LO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.Done !== 1'b0 || bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mul_max_idle: Done=%b state=%0d expected 0/0", bus.Done, bus.dbg_state);
    end
  endtask

  task automatic test_mul_vectors();
    logic [31:0] va[4] = '{32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 32'h1234_5678};
    logic [31:0] vb[4] = '{32'h0000_0002, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0010};
    logic [31:0] eh[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    logic [31:0] el[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h2345_6780};
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(1'b0, va[i], vb[i]);
      wait_done(0, n);
      checks++;
      if (n !== 33 || bus.HI !== eh[i] || bus.LO !== el[i]) begin
        errors++;
        $display("FAIL mul_vec%0d: done@%0d HI=%h LO=%h expected done@33 HI=%h LO=%h",
                 i, n, bus.HI, bus.LO, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va[5] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb[5] = '{32'd7, 32'd1, 32'd10, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] eq[5] = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h2AAA_AAAA};
    logic [31:0] er[5] = '{32'd2, 32'd0, 32'd5, 32'd0, 32'd2};
    int n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(1'b1, va[i], vb[i]);
      wait_done(0, n);
      checks++;
      if (n !== 33 || bus.LO !== eq[i] || bus.HI !== er[i] || bus.Div_Zero !== 1'b0) begin
        errors++;
        $display("FAIL div_vec%0d: done@%0d LO=%h HI=%h dz=%b expected done@33 LO=%h HI=%h dz=0",
                 i, n, bus.LO, bus.HI, bus.Div_Zero, eq[i], er[i]);
      end
    end
    @(negedge clk);
    issue(1'b1, 32'h1234_5678, 32'h0);
    wait_done(0, n);
    checks++;
    if (n !== 33 || bus.LO !== 32'hFFFF_FFFF || bus.HI !== 32'h1234_5678) begin
      errors++;
      $display("FAIL div_zero_result: done@%0d LO=%h HI=%h expected done@33 ffffffff/12345678",
               n, bus.LO, bus.HI);
    end
    checks++;
    if (bus.Div_Zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_flag: Div_Zero=%b expected 1", bus.Div_Zero);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.Div_Zero !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_pulse: Div_Zero=%b Done=%b expected 0/0", bus.Div_Zero, bus.Done);
    end
  endtask

  task automatic test_hazards();
    int stall_bad;
    int hold_bad;
    int n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = bus.HI;
    old_lo = bus.LO;
    @(negedge clk);
    issue(1'b0, 32'd3, 32'd5);
    stall_bad = 0;
    hold_bad  = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus.Start    = (c == 10);
      bus.SrcA     = 32'hDEAD_BEEF;
      bus.SrcB     = 32'h0BAD_F00D;
      bus.Op       = 1'b1;
      bus.Read_Req = (c >= 5);
      #1;
      if (bus.Stall !== (c >= 5)) stall_bad++;
      if (bus.HI !== old_hi || bus.LO !== old_lo) hold_bad++;
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL hazard_stall: %0d cycles with wrong Stall expected 0", stall_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL hazard_hilo_hold: %0d cycles with changed HI/LO expected 0", hold_bad);
    end
    @(negedge clk);
    issue(1'b0, 32'd4, 32'd4);
    #1;
    checks++;
    if (bus.Done !== 1'b1 || bus.Stall !== 1'b0 || bus.LO !== 32'd15 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL hazard_done: Done=%b Stall=%b LO=%h HI=%h expected 1/0/0000000f/00000000",
               bus.Done, bus.Stall, bus.LO, bus.HI);
    end
    @(negedge clk);
    bus.Start    = 1'b0;
    bus.Read_Req = 1'b0;
    #1;
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL hazard_accept_in_done: Busy=%b expected 1", bus.Busy);
    end
    wait_done(1, n);
    checks++;
    if (n !== 33 || bus.LO !== 32'd16 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL hazard_second_op: done@%0d LO=%h HI=%h expected done@33 00000010/00000000",
               n, bus.LO, bus.HI);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    issue(1'b0, 32'd2, 32'd3);
    wait_done(0, n);
    checks++;
    if (n !== 33 || bus.LO !== 32'd6 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: done@%0d LO=%h HI=%h expected done@33 00000006/00000000",
               n, bus.LO, bus.HI);
    end
    issue(1'b1, 32'd9, 32'd2);
    wait_done(0, n);
    checks++;
    if (n !== 33 || bus.LO !== 32'd4 || bus.HI !== 32'd1 || bus.Div_Zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done@%0d LO=%h HI=%h dz=%b expected done@33 00000004/00000001/0",
               n, bus.LO, bus.HI, bus.Div_Zero);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int done_seen;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd9);
    repeat (9) begin
      @(negedge clk);
      bus.Start = 1'b0;
    end
    @(negedge clk);
    bus.Read_Req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++;
      $display("FAIL midreset_hilo: HI=%h LO=%h expected 0/0", bus.HI, bus.LO);
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Stall !== 1'b0 || bus.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_flags: Busy=%b Stall=%b state=%0d expected 0/0/0",
               bus.Busy, bus.Stall, bus.dbg_state);
    end
    bus.Read_Req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      #1;
      if (bus.Done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midreset_no_done: Done seen %0d cycles expected 0", done_seen);
    end
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd9);
    wait_done(0, n);
    checks++;
    if (n !== 33 || bus.LO !== 32'd63 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL midreset_reissue: done@%0d LO=%h HI=%h expected done@33 0000003f/00000000",
               n, bus.LO, bus.HI);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b1;
    bus.Start    = 1'b0;
    bus.Op       = 1'b0;
    bus.SrcA     = '0;
    bus.SrcB     = '0;
    bus.Read_Req = 1'b0;
    test_reset();
    test_mul_max();
    test_mul_vectors();
    test_div();
    test_hazards();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and iterative datapath for MULTU/DIVU. It owns the 64-bit HI/LO result register that the control unit's WE_R64 strobe targets. It accepts an issue pulse from decode, runs a 1-bit-per-cycle shift-add multiply or restoring divide, and loads HI/LO. It also drives the pipeline stall when a HI/LO read or a new issue arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  issue strobe (decode WE_R64 for MULTU/DIVU), sampled at clk edge
Op  input  1  0 = MULTU, 1 = DIVU; sampled with Start
SrcA  input  WIDTH  multiplicand / dividend, sampled with Start
SrcB  input  WIDTH  multiplier / divisor, sampled with Start
Read_Req  input  1  MFHI/MFLO in decode this cycle
HI  output  WIDTH  HI register (product upper half / remainder)
LO  output  WIDTH  LO register (product lower half / quotient)
Busy  output  1  operation in flight (state RUN)
Done  output  1  one-cycle pulse; HI/LO hold the new result this cycle
Div_Zero  output  1  high with Done when completed DIVU had SrcB = 0
Stall  output  1  combinational pipeline stall

Behaviour:
- Reset (async, rst_n = 0): state IDLE; HI = LO = 0; Busy = Done = Div_Zero = 0; all internal operand, accumulator and counter registers = 0. Stall = 0 while in reset.
- States: IDLE, RUN, DONE. Start is accepted in IDLE or DONE; both behave identically for acceptance.
- Accept (Start = 1 in IDLE/DONE): latch Op and operands; counter = WIDTH; state goes to RUN.
  - MUL init: acc_hi = 0, acc_lo = SrcB, mcand = SrcA.
  - DIV init: rem = 0 (WIDTH+1 bits), quo = SrcA, dvsr = SrcB.
- RUN, one iteration per cycle; counter decrements each cycle.
  - MUL: {c, acc_hi} = acc_hi + (acc_lo[0] ? mcand : 0), with a WIDTH+1-bit sum. Then {acc_hi, acc_lo} = {c, acc_hi, acc_lo} >> 1.
  - DIV: {rem, quo} shifted left 1. diff = rem - dvsr, computed WIDTH+1 bits wide. If diff is non-negative, rem = diff and quo[0] = 1; otherwise quo[0] = 0.
- Final iteration (counter == 1): the same edge loads HI/LO, and state goes to DONE.
  - MUL: HI = acc_hi, LO = acc_lo.
  - DIV: HI = rem[WIDTH-1:0], LO = quo.
- DONE lasts 1 cycle with Done = 1. If Start = 1 in DONE, the new operation is accepted and state goes to RUN; otherwise state goes to IDLE.
- Latency: Start sampled at edge 0 → Busy = 1 for cycles 1..WIDTH → Done = 1 in cycle WIDTH+1 with HI/LO valid. Issue-to-issue minimum is WIDTH+1 cycles.
- Divide by zero: no special path. The algorithm naturally yields LO = all ones and HI = SrcA. Div_Zero = 1 in the DONE cycle (registered from the latched divisor == 0); otherwise Div_Zero = 0.
- HI/LO change only on the final-iteration edge and hold otherwise. Intermediate values are never visible on HI/LO.
- Stall = Busy & (Read_Req | Start).
  - A Start while in RUN is not accepted; the pipeline holds it until DONE/IDLE.
  - Read_Req in IDLE/DONE does not stall and returns the current HI/LO. A Read_Req in the same cycle as an accepted Start sees the old HI/LO, preserving program order.
- Op, SrcA and SrcB changes during RUN are ignored.
- Reset asserted mid-RUN aborts the operation. No Done is generated, HI/LO = 0, and state returns to IDLE.

Test Plan:
- Reset: rst_n low for 2 cycles → HI = LO = 0, Busy = Done = Stall = Div_Zero = 0; the async clear takes effect without a clock edge.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start at cycle 0 → Busy in cycles 1..32; Done in cycle 33 with HI = 0xFFFFFFFE, LO = 0x00000001; Busy = 0 in cycle 33.
- DIVU 100 / 7 → Done in cycle 33, LO = 14, HI = 2, Div_Zero = 0. Then DIVU 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678, Div_Zero = 1 for exactly the Done cycle.
- Hazards: Read_Req held from cycle 5 of a MULTU 3 × 5 → Stall = 1 cycles 5..32, Stall = 0 in cycle 33 with LO = 15, HI = 0. A Start pulsed in cycle 10 is not accepted (Stall = 1, HI/LO unaffected). A Start held in the Done cycle is accepted, with Busy = 1 the next cycle.
- Back-to-back: MULTU 2 × 3 followed by DIVU 9 / 2 issued in its Done cycle → first Done has LO = 6. Second Done follows exactly 33 cycles later with LO = 4, HI = 1.
- Mid-op reset: MULTU 7 × 9, rst_n low in cycle 10 → HI = LO = 0 and Busy = 0 immediately, and no Done follows. Then re-release and issue MULTU 7 × 9 → LO = 63 at cycle 33 after the Start.
